// File: rtl/frog_pkg.sv
// -----------------------------------------------------------------------------
// frog_pkg
// Shared types and playfield geometry for the frog game controller.
//   game_state_e : controller state, also driven out as GameState
//   NUM_LANES    : number of car lanes
//   LANE_H       : lane height in pixels
//   CAR_W        : car width in pixels
//   LANE_Y       : top Y coordinate of each lane, lane 0 first
// -----------------------------------------------------------------------------
package frog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_H    = 32;
    localparam int CAR_W     = 32;

    localparam logic [10:0] LANE_Y [0:NUM_LANES-1] = '{11'd370, 11'd330, 11'd290, 11'd250};

endpackage

// File: rtl/frog_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// frog_game_ctrl_if
// Signal bundle between the game top level (master) and the controller (slave).
//   Start      : level start key, sampled every frame
//   FrogX/Y/S  : frog centre and half-size from the motion block
//   CarX       : four packed 10-bit car left edges, lane 0 in [9:0]
//   Respawn    : one-frame registered pulse that resets the motion block
//   GameState  : IDLE=0, PLAY=1, DYING=2, OVER=3
//   Lives      : remaining lives
//   Score      : score in points
//   TimeLeft   : frames remaining for the current life
// There is no valid/ready handshake on this bundle: every input is a level
// sampled on each frame_clk edge, every output is a register updated on it.
// -----------------------------------------------------------------------------
interface frog_game_ctrl_if;

    logic        Start;
    logic [9:0]  FrogX;
    logic [9:0]  FrogY;
    logic [9:0]  FrogS;
    logic [39:0] CarX;
    logic        Respawn;
    logic [1:0]  GameState;
    logic [1:0]  Lives;
    logic [9:0]  Score;
    logic [10:0] TimeLeft;

    modport master (
        output Start, FrogX, FrogY, FrogS, CarX,
        input  Respawn, GameState, Lives, Score, TimeLeft
    );

    modport slave (
        input  Start, FrogX, FrogY, FrogS, CarX,
        output Respawn, GameState, Lives, Score, TimeLeft
    );

endinterface

// File: rtl/frog_lane_hit.sv
// -----------------------------------------------------------------------------
// frog_lane_hit
// Combinational collision test of the frog against the car in one lane.
//   LANE_TOP : top Y of this lane
//   frog_x   : frog centre X
//   frog_y   : frog centre Y
//   frog_s   : frog half-size
//   car_x    : car left edge X
//   hit      : frog centre Y inside the lane and X spans overlap
// All arithmetic is 11-bit unsigned so right edges cannot wrap; the frog left
// edge clamps at 0 instead of wrapping below it.
// -----------------------------------------------------------------------------
module frog_lane_hit
    import frog_pkg::*;
#(
    parameter logic [10:0] LANE_TOP = 11'd370
) (
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    input  logic [9:0] frog_s,
    input  logic [9:0] car_x,
    output logic       hit
);

    logic [10:0] frog_left;
    logic [10:0] frog_right;
    logic [10:0] car_left;
    logic [10:0] car_right;
    logic [10:0] y_ext;
    logic        in_lane;

    always_comb begin
        frog_left  = (frog_x >= frog_s) ? ({1'b0, frog_x} - {1'b0, frog_s}) : 11'd0;
        frog_right = {1'b0, frog_x} + {1'b0, frog_s};
        car_left   = {1'b0, car_x};
        car_right  = car_left + 11'(CAR_W - 1);
        y_ext      = {1'b0, frog_y};
        in_lane    = (y_ext >= LANE_TOP) && (y_ext <= LANE_TOP + 11'(LANE_H - 1));
        hit        = in_lane && (frog_left <= car_right) && (car_left <= frog_right);
    end

endmodule

// File: rtl/frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// frog_game_ctrl
// Game controller for the frog crossing game: start/restart, hit detection
// against four car lanes, scoring at the goal line, death hold and game over.
//   frame_clk : frame clock (~60 Hz)
//   Reset     : asynchronous, active-high reset
//   bus       : frog_game_ctrl_if.slave (Start, frog/car positions in;
//               Respawn, GameState, Lives, Score, TimeLeft out)
// Optional build macro FROG_TIMER_EN adds a per-life frame timer; when it is
// undefined TimeLeft is tied to 0 and there is no timeout.
// -----------------------------------------------------------------------------
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int HIT_HOLD     = 90,
    parameter int GOAL_Y       = 58,
    parameter int TIMER_FRAMES = 1800
) (
    input  logic         frame_clk,
    input  logic         Reset,
    frog_game_ctrl_if.slave bus
);

    // Elaboration-time range checks on the configuration.
    if (LIVES_INIT < 1 || LIVES_INIT > 3) begin : g_bad_lives
        $error("LIVES_INIT must be 1..3");
    end
    if (HIT_HOLD < 1 || HIT_HOLD > 65535) begin : g_bad_hold
        $error("HIT_HOLD must be 1..65535");
    end
    if (TIMER_FRAMES < 1 || TIMER_FRAMES > 2047) begin : g_bad_timer
        $error("TIMER_FRAMES must fit in TimeLeft");
    end

    game_state_e           state, state_n;
    logic [1:0]            lives, lives_n;
    logic [9:0]            score, score_n;
    logic                  respawn, respawn_n;
    logic [15:0]           hold_cnt, hold_n;
    logic [NUM_LANES-1:0]  lane_hit;
    logic                  timeout;
    logic                  hit_frame;
    logic                  goal_frame;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        frog_lane_hit #(
            .LANE_TOP (LANE_Y[i])
        ) u_lane_hit (
            .frog_x (bus.FrogX),
            .frog_y (bus.FrogY),
            .frog_s (bus.FrogS),
            .car_x  (bus.CarX[i*10 +: 10]),
            .hit    (lane_hit[i])
        );
    end

    // In a Respawn frame the motion block is being reset, so the frog
    // position is stale; ignore it. This also keeps a goal from producing a
    // second Respawn pulse back to back.
    assign hit_frame  = !respawn && ((|lane_hit) || timeout);
    assign goal_frame = !respawn && (bus.FrogY <= 10'(GOAL_Y));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            lives    <= 2'd0;
            score    <= 10'd0;
            respawn  <= 1'b0;
            hold_cnt <= 16'd0;
        end else begin
            state    <= state_n;
            lives    <= lives_n;
            score    <= score_n;
            respawn  <= respawn_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        score_n   = score;
        respawn_n = 1'b0;
        hold_n    = hold_cnt;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (bus.Start) begin
                    state_n   = ST_PLAY;
                    lives_n   = 2'(LIVES_INIT);
                    score_n   = 10'd0;
                    respawn_n = 1'b1;
                end
            end
            ST_PLAY: begin
                hold_n = 16'd0;
                // A hit wins over a goal seen in the same frame.
                if (hit_frame) begin
                    state_n = ST_DYING;
                    lives_n = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                end else if (goal_frame) begin
                    score_n   = (score > 10'd980) ? 10'd990 : score + 10'd10;
                    respawn_n = 1'b1;
                end
            end
            ST_DYING: begin
                if (hold_cnt == 16'(HIT_HOLD - 1)) begin
                    hold_n = 16'd0;
                    if (lives == 2'd0) begin
                        state_n = ST_OVER;
                    end else begin
                        state_n   = ST_PLAY;
                        respawn_n = 1'b1;
                    end
                end else begin
                    hold_n = hold_cnt + 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

`ifdef FROG_TIMER_EN
    logic [10:0] time_left, time_left_n;

    // The Respawn frame itself counts as the first frame of the budget.
    assign timeout = (state == ST_PLAY) && (time_left == 11'd0);

    always_comb begin
        time_left_n = time_left;
        if (respawn_n) begin
            time_left_n = 11'(TIMER_FRAMES);
        end else if (state == ST_PLAY && time_left != 11'd0) begin
            time_left_n = time_left - 11'd1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            time_left <= 11'd0;
        end else begin
            time_left <= time_left_n;
        end
    end

    assign bus.TimeLeft = time_left;
`else
    assign timeout      = 1'b0;
    assign bus.TimeLeft = 11'd0;
`endif

    assign bus.Respawn   = respawn;
    assign bus.GameState = state;
    assign bus.Lives     = lives;
    assign bus.Score     = score;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_game_ctrl
// Self-checking bench for frog_game_ctrl. A frame-level game model predicts
// every output each frame; directed sequences cover start, death hold, edge
// clamping, scoring, game over, restart, timer and reset mid-hold, followed by
// randomized play. A second instance with the goal line moved into lane 0
// exercises hit-over-goal priority, which the default geometry cannot reach.
// -----------------------------------------------------------------------------
module tb_frog_game_ctrl;

    localparam int HOLD = 90;
    localparam int TMR  = 200;
    localparam int GOAL = 58;
`ifdef FROG_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic frame_clk = 1'b0;
    logic Reset;
    always #5 frame_clk = ~frame_clk;

    frog_game_ctrl_if bus ();
    frog_game_ctrl_if bus2 ();

    frog_game_ctrl #(
        .LIVES_INIT (3), .HIT_HOLD (HOLD), .GOAL_Y (GOAL), .TIMER_FRAMES (TMR)
    ) dut (
        .frame_clk (frame_clk), .Reset (Reset), .bus (bus)
    );

    frog_game_ctrl #(
        .LIVES_INIT (3), .HIT_HOLD (HOLD), .GOAL_Y (400), .TIMER_FRAMES (1800)
    ) dut_goal (
        .frame_clk (frame_clk), .Reset (Reset), .bus (bus2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [25:0] exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_state, m_lives, m_score, m_resp, m_tl, m_dying_left;

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_score = 0; m_resp = 0; m_tl = 0; m_dying_left = 0;
        exp_q.delete();
    endtask

    function automatic bit model_hit();
        int tops[4] = '{370, 330, 290, 250};
        int fy, left, right, cl;
        fy    = int'(bus.FrogY);
        left  = int'(bus.FrogX) - int'(bus.FrogS);
        if (left < 0) left = 0;
        right = int'(bus.FrogX) + int'(bus.FrogS);
        for (int i = 0; i < 4; i++) begin
            cl = int'(bus.CarX[i*10 +: 10]);
            if (fy >= tops[i] && fy < tops[i] + 32 && left < cl + 32 && cl <= right) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int  old_state = m_state;
        int  nresp = 0;
        bit  hit, goal;
        hit  = (m_resp == 0) && (model_hit() || (TIMER_ON && m_state == 1 && m_tl == 0));
        goal = (m_resp == 0) && (int'(bus.FrogY) <= GOAL);
        case (m_state)
            0, 3: if (bus.Start) begin
                m_state = 1; m_lives = 3; m_score = 0; nresp = 1;
            end
            1: if (hit) begin
                m_state = 2; m_lives = m_lives - 1; m_dying_left = HOLD;
            end else if (goal) begin
                m_score = (m_score + 10 > 990) ? 990 : m_score + 10;
                nresp = 1;
            end
            default: begin
                m_dying_left = m_dying_left - 1;
                if (m_dying_left == 0) begin
                    if (m_lives == 0) m_state = 3;
                    else begin m_state = 1; nresp = 1; end
                end
            end
        endcase
        if (TIMER_ON) begin
            if (nresp == 1) m_tl = TMR;
            else if (old_state == 1 && m_tl > 0) m_tl = m_tl - 1;
        end
        m_resp = nresp;
        exp_q.push_back({2'(m_state), 2'(m_lives), 10'(m_score), 1'(m_resp), 11'(m_tl)});
    endtask

    task automatic check_all();
        logic [25:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("state",    int'(bus.GameState), int'(e[25:24]));
        check("lives",    int'(bus.Lives),     int'(e[23:22]));
        check("score",    int'(bus.Score),     int'(e[21:12]));
        check("respawn",  int'(bus.Respawn),   int'(e[11]));
        check("timeleft", int'(bus.TimeLeft),  int'(e[10:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_frog(input int x, input int y, input int s);
        bus.FrogX = 10'(x); bus.FrogY = 10'(y); bus.FrogS = 10'(s);
    endtask

    task automatic set_car(input int lane, input int x);
        bus.CarX[lane*10 +: 10] = 10'(x);
    endtask

    task automatic neutral();
        set_frog(500, 200, 8);
        bus.CarX = {4{10'd900}};
    endtask

    // Called just after a posedge: asserts Reset mid-frame and releases it
    // on the following negedge.
    task automatic apply_reset();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check("rst_state",   int'(bus.GameState), 0);
        check("rst_lives",   int'(bus.Lives),     0);
        check("rst_score",   int'(bus.Score),     0);
        check("rst_respawn", int'(bus.Respawn),   0);
        check("rst_tl",      int'(bus.TimeLeft),  0);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int y_cat, fx, fs, tops[4];
        tops = '{370, 330, 290, 250};
        Reset = 1'b1;
        bus.Start = 1'b0;
        neutral();
        bus2.Start = 1'b0;
        bus2.FrogX = 10'd500; bus2.FrogY = 10'd500; bus2.FrogS = 10'd8;
        bus2.CarX  = {4{10'd900}};
        repeat (2) @(negedge frame_clk);
        model_reset();
        check("por_state",   int'(bus.GameState), 0);
        check("por_lives",   int'(bus.Lives),     0);
        check("por_score",   int'(bus.Score),     0);
        check("por_respawn", int'(bus.Respawn),   0);
        check("por_tl",      int'(bus.TimeLeft),  0);
        Reset = 1'b0;

        // Hit and goal together on the instance whose goal line covers lane 0.
        bus2.Start = 1'b1;
        tick();
        check("g_start_state", int'(bus2.GameState), 1);
        bus2.Start = 1'b0;
        tick();
        bus2.FrogX = 10'd100; bus2.FrogY = 10'd380; bus2.CarX[9:0] = 10'd104;
        tick();
        check("g_prio_state", int'(bus2.GameState), 2);
        check("g_prio_score", int'(bus2.Score),     0);
        check("g_prio_lives", int'(bus2.Lives),     2);
        bus2.CarX[9:0] = 10'd900;
        ticks(HOLD);
        check("g_back_state",   int'(bus2.GameState), 1);
        check("g_back_respawn", int'(bus2.Respawn),   1);
        tick();
        check("g_supp_score", int'(bus2.Score), 0);
        tick();
        check("g_goal_score",   int'(bus2.Score),   10);
        check("g_goal_respawn", int'(bus2.Respawn), 1);
        bus2.FrogY = 10'd500;

        // Start for one frame.
        bus.Start = 1'b1;
        tick();
        check("start_state",   int'(bus.GameState), 1);
        check("start_lives",   int'(bus.Lives),     3);
        check("start_score",   int'(bus.Score),     0);
        check("start_respawn", int'(bus.Respawn),   1);
        bus.Start = 1'b0;
        tick();
        check("start_respawn_width", int'(bus.Respawn), 0);

        // Lane 0 hit, then the full death hold.
        set_frog(100, 380, 8); set_car(0, 104);
        tick();
        check("hit_state", int'(bus.GameState), 2);
        check("hit_lives", int'(bus.Lives),     2);
        neutral();
        ticks(HOLD - 1);
        check("hold_state", int'(bus.GameState), 2);
        tick();
        check("hold_exit_state",   int'(bus.GameState), 1);
        check("hold_exit_respawn", int'(bus.Respawn),   1);
        tick();

        // Left edge clamps at 0.
        set_frog(5, 375, 8); set_car(0, 0);
        tick();
        check("clamp_hit_state", int'(bus.GameState), 2);
        check("clamp_hit_lives", int'(bus.Lives),     1);
        neutral();
        ticks(HOLD);
        tick();
        set_frog(5, 375, 8); set_car(0, 14);
        tick();
        check("clamp_miss_state", int'(bus.GameState), 1);

        // Goal exactly on the line.
        set_frog(500, GOAL, 8); set_car(0, 900);
        tick();
        check("goal_score",   int'(bus.Score),   10);
        check("goal_respawn", int'(bus.Respawn), 1);
        neutral();
        tick();
        check("goal_respawn_width", int'(bus.Respawn), 0);

        // Start held while playing does nothing.
        bus.Start = 1'b1;
        ticks(3);
        check("hold_start_state", int'(bus.GameState), 1);
        check("hold_start_score", int'(bus.Score),     10);
        bus.Start = 1'b0;

        // Last life lost, game over, restart.
        set_frog(100, 380, 8); set_car(0, 104);
        tick();
        check("last_hit_lives", int'(bus.Lives), 0);
        neutral();
        ticks(HOLD);
        check("over_state", int'(bus.GameState), 3);
        check("over_lives", int'(bus.Lives),     0);
        ticks(5);
        check("over_hold_state", int'(bus.GameState), 3);
        check("over_hold_score", int'(bus.Score),     10);
        bus.Start = 1'b1;
        tick();
        check("restart_state", int'(bus.GameState), 1);
        check("restart_lives", int'(bus.Lives),     3);
        check("restart_score", int'(bus.Score),     0);
        bus.Start = 1'b0;
        tick();

        // Idle frog: timeout in the timer build, endless PLAY otherwise.
        if (TIMER_ON) begin
            ticks(TMR - 1);
            check("timer_zero_state", int'(bus.GameState), 1);
            check("timer_zero_tl",    int'(bus.TimeLeft),  0);
            tick();
            check("timeout_state", int'(bus.GameState), 2);
        end else begin
            ticks(250);
            check("notimer_state", int'(bus.GameState), 1);
            check("notimer_tl",    int'(bus.TimeLeft),  0);
        end

        // Reset in the middle of the death hold.
        set_frog(100, 380, 8); set_car(0, 104);
        tick();
        neutral();
        ticks(10);
        apply_reset();
        tick();
        check("post_rst_state",   int'(bus.GameState), 0);
        check("post_rst_respawn", int'(bus.Respawn),   0);

        // Randomized play.
        for (int f = 0; f < 3000; f++) begin
            bus.Start = ($urandom_range(0, 15) == 0);
            fx = $urandom_range(0, 1023);
            fs = $urandom_range(0, 40);
            y_cat = $urandom_range(0, 3);
            case (y_cat)
                0: set_frog(fx, $urandom_range(0, GOAL + 1), fs);
                1: set_frog(fx, tops[$urandom_range(0, 3)] + $urandom_range(0, 31), fs);
                2: set_frog(fx, tops[$urandom_range(0, 3)] + ($urandom_range(0, 1) ? 32 : -1), fs);
                default: set_frog(fx, $urandom_range(GOAL + 1, 249), fs);
            endcase
            for (int l = 0; l < 4; l++) begin
                int c;
                if ($urandom_range(0, 1) == 1) begin
                    c = fx + $urandom_range(0, 80) - 40;
                    if (c < 0) c = 0;
                    if (c > 1023) c = 1023;
                end else begin
                    c = $urandom_range(0, 1023);
                end
                set_car(l, c);
            end
            if ($urandom_range(0, 499) == 0) begin
                @(posedge frame_clk);
                apply_reset();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frog_game_ctrl.md
FROG_GAME_CTRL -- requirements
Module: frog_game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 Parameter HIT_HOLD, default 90, frames spent in DYING.
REQ-003 Parameter GOAL_Y, default 58, frog-centre Y at or above which the goal counts.
REQ-004 Parameter TIMER_FRAMES, default 1800, per-life time budget in frames (timer build only).
REQ-005 Port frame_clk, input, 1, frame clock (~60 Hz).
REQ-006 Port Reset, input, 1, asynchronous, active-high reset.
REQ-007 Port Start, input, 1, level; decoded start key, sampled each frame.
REQ-008 Ports FrogX, FrogY, FrogS, input, 10 each, frog centre and half-size from the motion block.
REQ-009 Port CarX, input, 40, four packed 10-bit car left-edge X values, lane 0 in [9:0].
REQ-010 Port Respawn, output, 1, one-frame pulse; the top level ORs it into the motion block's reset.
REQ-011 Port GameState, output, 2, IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-012 Port Lives, output, 2, remaining lives.
REQ-013 Port Score, output, 10, score in points.
REQ-014 Port TimeLeft, output, 11, frames remaining for the current life.

Function
REQ-015 Hit on lane i SHALL be frog Y in [LANE_Y[i], LANE_Y[i]+LANE_H-1] and [max(FrogX-FrogS,0), FrogX+FrogS] overlapping [CarX[i], CarX[i]+CAR_W-1].
REQ-016 All overlap arithmetic SHALL use 11-bit unsigned values; the left edge SHALL clamp at 0 with no wrap.
REQ-017 IDLE SHALL go to PLAY on Start=1, loading Lives=LIVES_INIT and Score=0, and pulsing Respawn.
REQ-018 In PLAY, any lane hit SHALL cause entry to DYING on the next edge, with Lives decremented by 1 on entry.
REQ-019 In PLAY with no hit and FrogY <= GOAL_Y, Score SHALL add 10 (saturating at 990), Respawn SHALL pulse, and state SHALL stay PLAY.
REQ-020 Hit and goal in the same frame SHALL be resolved as a hit only.
REQ-021 Goal and hit detection SHALL be suppressed in any frame where Respawn is 1.
REQ-022 DYING SHALL hold for exactly HIT_HOLD frames; at expiry it goes to OVER if Lives==0, else to PLAY with a Respawn pulse.
REQ-023 OVER SHALL hold all outputs; Start=1 reloads Lives and Score, pulses Respawn, and enters PLAY.
REQ-024 Respawn SHALL be registered, exactly one frame wide, and never asserted in two consecutive frames.
REQ-025 Start held continuously SHALL NOT retrigger a restart while in PLAY or DYING.

Reset
REQ-026 Reset SHALL force GameState=IDLE, Lives=0, Score=0, TimeLeft=0, Respawn=0, and clear the hold counter, asynchronously.
REQ-027 Reset asserted mid-DYING SHALL abandon the hold; IDLE is entered with no Respawn pulse.

Configuration
REQ-028 With FROG_TIMER_EN defined, TimeLeft SHALL load TIMER_FRAMES on each Respawn and decrement once per PLAY frame.
REQ-029 With FROG_TIMER_EN defined, TimeLeft reaching 0 in PLAY SHALL be treated exactly as a hit; a timeout and a goal in the same frame count as a hit.
REQ-030 Without FROG_TIMER_EN, TimeLeft SHALL be tied to 0 and no timeout path SHALL exist.

Structure
REQ-031 Package frog_pkg SHALL hold the state enum, NUM_LANES=4, LANE_H=32, CAR_W=32 and LANE_Y[0:3]={370,330,290,250}.
REQ-032 Sub-module frog_lane_hit (combinational, one per lane) SHALL compute the per-lane overlap; the top module ORs the four results.

Verification
REQ-033 Reset, then Start=1 for 1 frame -> GameState=1, Lives=3, Score=0, Respawn high for exactly 1 frame.
REQ-034 FrogX=100, FrogY=380, FrogS=8, CarX lane0=104 -> DYING next frame, Lives=2, and PLAY with a Respawn pulse 90 frames later.
REQ-035 FrogX=5, FrogS=8, CarX lane0=0, FrogY=375 -> hit detected (clamp, no wrap); with CarX lane0=14 -> no hit.
REQ-036 FrogY=58 with no hit -> Score=10 and Respawn pulse; FrogY=58 together with a lane hit -> DYING and Score unchanged.
REQ-037 Three hits -> OVER with Lives=0; Start=1 -> PLAY, Lives=3, Score=0.
REQ-038 With FROG_TIMER_EN defined and TIMER_FRAMES=5, idle frog in PLAY -> DYING after 5 frames; without the macro -> TimeLeft stays 0 and no DYING.
